// File: rtl/cert_chain_sequencer_pkg.sv
// Shared definitions for the certificate chain sequencer: state encoding, result codes,
// slot identifiers and the per-slot certificate counts also used by the comparator table.
package cert_chain_sequencer_pkg;

    localparam int unsigned MSG_LEN                 = 96;
    localparam int unsigned SIZE_OF_HEADER_VARS     = 4;
    localparam int unsigned SIZE_OF_HEADER_IN_BYTES = 8;
    localparam int unsigned DEF_PAYLOAD_W           = MSG_LEN - (SIZE_OF_HEADER_VARS * SIZE_OF_HEADER_IN_BYTES);

    localparam int unsigned DEF_SLOT0_CERTS    = 6;
    localparam int unsigned DEF_SLOT1_CERTS    = 4;
    localparam int unsigned DEF_SLOT2_CERTS    = 5;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_CHECK,
        ST_EVAL,
        ST_DONE
    } seq_state_t;

    localparam logic [1:0] ERR_NONE         = 2'd0;
    localparam logic [1:0] ERR_MISMATCH     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT      = 2'd2;
    localparam logic [1:0] ERR_SLOT_VERDICT = 2'd3;

    localparam logic [1:0] SLOT0        = 2'd0;
    localparam logic [1:0] SLOT1        = 2'd1;
    localparam logic [1:0] SLOT2        = 2'd2;
    localparam logic [1:0] SLOT_INVALID = 2'd3;

    // Index of the final certificate in a slot; counts are constrained to 1..255.
    function automatic logic [7:0] last_index(
        input logic [1:0]  slot,
        input int unsigned c0,
        input int unsigned c1,
        input int unsigned c2
    );
        logic [7:0] v;
        v = '0;
        case (slot)
            SLOT0:   v = 8'(c0);
            SLOT1:   v = 8'(c1);
            SLOT2:   v = 8'(c2);
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/cert_chunk_timeout.sv
// Loadable down-counter guarding the chunk wait; o_expired flags the final allowed cycle
// while counting is enabled.
module cert_chunk_timeout #(
    parameter int unsigned LOAD_VALUE = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_clear,
    input  logic i_dec,
    output logic o_expired
);

    localparam int unsigned CW = (LOAD_VALUE < 1) ? 1 : $clog2(LOAD_VALUE + 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= CW'(LOAD_VALUE);
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CW'(1);
        end
    end

    assign o_expired = i_dec && (r_count == '0);

endmodule

// File: rtl/cert_chain_sequencer.sv
// Walks every certificate of a selected slot through the comparator, one chunk per
// request, and folds the per-chunk verdicts into a sticky chain pass/fail result.
module cert_chain_sequencer #(
    parameter int unsigned PAYLOAD_W      = cert_chain_sequencer_pkg::DEF_PAYLOAD_W,
    parameter int unsigned SLOT0_CERTS    = cert_chain_sequencer_pkg::DEF_SLOT0_CERTS,
    parameter int unsigned SLOT1_CERTS    = cert_chain_sequencer_pkg::DEF_SLOT1_CERTS,
    parameter int unsigned SLOT2_CERTS    = cert_chain_sequencer_pkg::DEF_SLOT2_CERTS,
    parameter int unsigned TIMEOUT_CYCLES = cert_chain_sequencer_pkg::DEF_TIMEOUT_CYCLES
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [1:0]           Slot_sel,
    input  logic                 Abort,
    output logic                 Req_chunk,
    output logic [7:0]           Req_index,
    input  logic                 Chunk_valid,
    output logic                 Chunk_ready,
    input  logic [PAYLOAD_W-1:0] Chunk_data,
    output logic                 Cmp_Enable,
    output logic [1:0]           Cmp_slot,
    output logic [7:0]           Cmp_counter,
    output logic [PAYLOAD_W-1:0] Cmp_payload,
    input  logic                 Cmp_valid,
    input  logic                 Cmp_error,
    output logic                 Busy,
    output logic                 Done,
    output logic                 Chain_valid,
    output logic                 Chain_error,
    output logic [1:0]           Err_code
);

    import cert_chain_sequencer_pkg::*;

    seq_state_t           r_state;
    logic [7:0]           r_counter;
    logic                 r_req_chunk;
    logic [7:0]           r_req_index;
    logic                 r_chunk_ready;
    logic                 r_cmp_enable;
    logic [1:0]           r_slot;
    logic [7:0]           r_cmp_counter;
    logic [PAYLOAD_W-1:0] r_cmp_payload;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_chain_valid;
    logic                 r_chain_error;
    logic [1:0]           r_err_code;

    logic       w_accept;
    logic       w_tmr_load;
    logic       w_tmr_dec;
    logic       w_expired;
    logic [7:0] w_last;

    assign w_accept   = (r_state == ST_WAIT) && Chunk_valid && r_chunk_ready;
    assign w_tmr_load = (r_state == ST_REQ);
    // Counting stops in the cycle a chunk lands, so a late chunk beats the timeout.
    assign w_tmr_dec  = (r_state == ST_WAIT) && !w_accept;
    assign w_last     = last_index(r_slot, SLOT0_CERTS, SLOT1_CERTS, SLOT2_CERTS);

    cert_chunk_timeout #(
        .LOAD_VALUE(TIMEOUT_CYCLES - 1)
    ) u_timeout (
        .clk      (clk),
        .rst      (Reset),
        .i_load   (w_tmr_load),
        .i_clear  (w_accept),
        .i_dec    (w_tmr_dec),
        .o_expired(w_expired)
    );

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state       <= ST_IDLE;
            r_counter     <= '0;
            r_req_chunk   <= 1'b0;
            r_req_index   <= '0;
            r_chunk_ready <= 1'b0;
            r_cmp_enable  <= 1'b0;
            r_slot        <= '0;
            r_cmp_counter <= '0;
            r_cmp_payload <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_chain_valid <= 1'b0;
            r_chain_error <= 1'b0;
            r_err_code    <= ERR_NONE;
        end else begin
            r_req_chunk <= 1'b0;
            r_done      <= 1'b0;
            if (Abort) begin
                r_state       <= ST_IDLE;
                r_busy        <= 1'b0;
                r_chunk_ready <= 1'b0;
                r_cmp_enable  <= 1'b0;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (Start) begin
                            r_chain_valid <= 1'b0;
                            r_chain_error <= 1'b0;
                            r_err_code    <= ERR_NONE;
                            r_slot        <= Slot_sel;
                            r_busy        <= 1'b1;
                            if (Slot_sel == SLOT_INVALID) begin
                                r_state       <= ST_DONE;
                                r_done        <= 1'b1;
                                r_chain_error <= 1'b1;
                                r_err_code    <= ERR_SLOT_VERDICT;
                            end else begin
                                r_counter   <= 8'd1;
                                r_req_chunk <= 1'b1;
                                r_req_index <= 8'd1;
                                r_state     <= ST_REQ;
                            end
                        end
                    end
                    ST_REQ: begin
                        r_chunk_ready <= 1'b1;
                        r_state       <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (w_accept) begin
                            r_cmp_payload <= Chunk_data;
                            r_cmp_counter <= r_counter;
                            r_chunk_ready <= 1'b0;
                            r_cmp_enable  <= 1'b1;
                            r_state       <= ST_CHECK;
                        end else if (w_expired) begin
                            r_chunk_ready <= 1'b0;
                            r_done        <= 1'b1;
                            r_chain_error <= 1'b1;
                            r_err_code    <= ERR_TIMEOUT;
                            r_state       <= ST_DONE;
                        end
                    end
                    ST_CHECK: begin
                        r_state <= ST_EVAL;
                    end
                    ST_EVAL: begin
                        // Dropping enable here leaves a low gap through REQ before the next chunk.
                        r_cmp_enable <= 1'b0;
                        if (Cmp_error) begin
                            r_done        <= 1'b1;
                            r_chain_error <= 1'b1;
                            r_err_code    <= ERR_MISMATCH;
                            r_state       <= ST_DONE;
                        end else if (Cmp_valid && (r_counter >= w_last)) begin
                            r_done        <= 1'b1;
                            r_chain_valid <= 1'b1;
                            r_state       <= ST_DONE;
                        end else if (Cmp_valid) begin
                            r_counter   <= r_counter + 8'd1;
                            r_req_chunk <= 1'b1;
                            r_req_index <= r_counter + 8'd1;
                            r_state     <= ST_REQ;
                        end else begin
                            r_done        <= 1'b1;
                            r_chain_error <= 1'b1;
                            r_err_code    <= ERR_SLOT_VERDICT;
                            r_state       <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign Req_chunk   = r_req_chunk;
    assign Req_index   = r_req_index;
    assign Chunk_ready = r_chunk_ready;
    assign Cmp_Enable  = r_cmp_enable;
    assign Cmp_slot    = r_slot;
    assign Cmp_counter = r_cmp_counter;
    assign Cmp_payload = r_cmp_payload;
    assign Busy        = r_busy;
    assign Done        = r_done;
    assign Chain_valid = r_chain_valid;
    assign Chain_error = r_chain_error;
    assign Err_code    = r_err_code;

endmodule

// File: tb/tb_cert_chain_sequencer.sv
// Scoreboard bench for cert_chain_sequencer: an upstream chunk source and a comparator
// stand-in run alongside per-scenario tasks that check chain results and sequencing.
module tb_cert_chain_sequencer;

    localparam int PW = 64;
    localparam int T  = 16;

    logic          clk;
    logic          Reset;
    logic          Start;
    logic [1:0]    Slot_sel;
    logic          Abort;
    logic          Req_chunk;
    logic [7:0]    Req_index;
    logic          Chunk_valid;
    logic          Chunk_ready;
    logic [PW-1:0] Chunk_data;
    logic          Cmp_Enable;
    logic [1:0]    Cmp_slot;
    logic [7:0]    Cmp_counter;
    logic [PW-1:0] Cmp_payload;
    logic          Cmp_valid;
    logic          Cmp_error;
    logic          Busy;
    logic          Done;
    logic          Chain_valid;
    logic          Chain_error;
    logic [1:0]    Err_code;

    cert_chain_sequencer #(
        .PAYLOAD_W     (PW),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk        (clk),
        .Reset      (Reset),
        .Start      (Start),
        .Slot_sel   (Slot_sel),
        .Abort      (Abort),
        .Req_chunk  (Req_chunk),
        .Req_index  (Req_index),
        .Chunk_valid(Chunk_valid),
        .Chunk_ready(Chunk_ready),
        .Chunk_data (Chunk_data),
        .Cmp_Enable (Cmp_Enable),
        .Cmp_slot   (Cmp_slot),
        .Cmp_counter(Cmp_counter),
        .Cmp_payload(Cmp_payload),
        .Cmp_valid  (Cmp_valid),
        .Cmp_error  (Cmp_error),
        .Busy       (Busy),
        .Done       (Done),
        .Chain_valid(Chain_valid),
        .Chain_error(Chain_error),
        .Err_code   (Err_code)
    );

    typedef struct {
        logic [1:0]    slot;
        logic [7:0]    idx;
        logic [PW-1:0] data;
    } chunk_exp_t;

    typedef struct {
        logic       valid;
        logic       error;
        logic [1:0] code;
    } res_exp_t;

    chunk_exp_t chunk_q[$];
    res_exp_t   res_q[$];
    int         req_log[$];

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   last_req_cyc = 0;
    int   done_cyc = 0;
    int   done_count = 0;
    int   en_rises = 0;
    int   en_run = 0;
    bit   en_prev = 0;
    bit   mon_quiet = 0;

    logic [1:0] cur_slot = 2'd0;
    int   silent_idx = 0;
    int   late_idx = 0;
    int   corrupt_idx = 0;
    int   both_idx = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [PW-1:0] chunk_word(input logic [1:0] s, input int idx);
        logic [7:0] b;
        b = 8'(idx);
        return {24'hC3A5F0, 6'd0, s, b, 16'hBEEF, ~b};
    endfunction

    // Upstream source: answers each request after a fixed gap, or at the last allowed cycle.
    initial begin : upstream
        int up_idx;
        int up_d;
        int up_b;
        chunk_exp_t up_e;
        Chunk_valid = 1'b0;
        Chunk_data  = '0;
        forever begin
            @(negedge clk);
            if (Req_chunk && (int'(Req_index) != silent_idx)) begin
                up_idx = int'(Req_index);
                up_d   = (up_idx == late_idx) ? T : 2;
                repeat (up_d) @(negedge clk);
                Chunk_data  = chunk_word(cur_slot, up_idx);
                Chunk_valid = 1'b1;
                up_e.slot = cur_slot;
                up_e.idx  = 8'(up_idx);
                up_e.data = Chunk_data;
                chunk_q.push_back(up_e);
                up_b = 0;
                while (!Chunk_ready && up_b < 8) begin
                    @(negedge clk);
                    up_b++;
                end
                if (!Chunk_ready) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL up_handshake: Chunk_ready=%0b for chunk %0d, required 1", Chunk_ready, up_idx);
                end
                @(negedge clk);
                Chunk_valid = 1'b0;
            end
        end
    end

    // Monitor, scoreboard consumer and comparator stand-in (verdict visible during EVAL).
    initial begin : monitor
        chunk_exp_t m_e;
        bit m_have;
        Cmp_valid = 1'b0;
        Cmp_error = 1'b0;
        forever begin
            @(negedge clk);
            if (Req_chunk) begin
                req_log.push_back(int'(Req_index));
                last_req_cyc = cyc;
            end
            if (Done) begin
                done_count++;
                done_cyc = cyc;
            end
            if (Cmp_Enable && !en_prev) begin
                en_rises++;
                en_run = 1;
                m_have = (chunk_q.size() != 0);
                n_cmp++;
                if (!m_have) begin
                    n_bad++;
                    $display("FAIL sb_empty: Cmp_Enable rose with counter %0d, required an outstanding chunk", Cmp_counter);
                    Cmp_valid = 1'b0;
                    Cmp_error = 1'b0;
                end else begin
                    m_e = chunk_q.pop_front();
                    if ({Cmp_slot, Cmp_counter, Cmp_payload} !== {m_e.slot, m_e.idx, m_e.data}) begin
                        n_bad++;
                        $display("FAIL sb_chunk: got slot %0d idx %0d data %h, required slot %0d idx %0d data %h",
                                 Cmp_slot, Cmp_counter, Cmp_payload, m_e.slot, m_e.idx, m_e.data);
                    end
                    Cmp_error = (int'(m_e.idx) == corrupt_idx) || (int'(m_e.idx) == both_idx);
                    Cmp_valid = (int'(m_e.idx) != corrupt_idx);
                end
            end else if (Cmp_Enable) begin
                en_run++;
            end else if (en_prev) begin
                Cmp_valid = 1'b0;
                Cmp_error = 1'b0;
                if (!mon_quiet) begin
                    n_cmp++;
                    if (en_run !== 2) begin
                        n_bad++;
                        $display("FAIL en_width: Cmp_Enable high %0d cycles, required 2", en_run);
                    end
                end
            end
            en_prev = Cmp_Enable;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic config_clear();
        silent_idx  = 0;
        late_idx    = 0;
        corrupt_idx = 0;
        both_idx    = 0;
        chunk_q.delete();
        res_q.delete();
        req_log.delete();
        done_count = 0;
        en_rises   = 0;
    endtask

    task automatic start_chain(input logic [1:0] slot, input logic ev, input logic ee, input logic [1:0] ec);
        res_exp_t r;
        @(negedge clk);
        cur_slot = slot;
        Slot_sel = slot;
        Start    = 1'b1;
        r.valid = ev;
        r.error = ee;
        r.code  = ec;
        res_q.push_back(r);
        start_cyc = cyc;
        @(posedge clk);
        #1;
        Start    = 1'b0;
        Slot_sel = 2'd0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen;
        res_exp_t r;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = Done;
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL %s_done: Done not seen within %0d cycles, required a pulse", name, budget);
        end else if (res_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s_done: Done pulsed with no result expected", name);
        end else begin
            r = res_q.pop_front();
            if ({Chain_valid, Chain_error, Err_code} !== {r.valid, r.error, r.code}) begin
                n_bad++;
                $display("FAIL %s_result: valid/error/code %0b/%0b/%0d, required %0b/%0b/%0d",
                         name, Chain_valid, Chain_error, Err_code, r.valid, r.error, r.code);
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({Req_chunk, Req_index, Chunk_ready, Cmp_Enable, Cmp_slot, Cmp_counter} !== '0) begin
            n_bad++;
            $display("FAIL reset_ctrl: req %0b idx %0d rdy %0b en %0b slot %0d cnt %0d, required all 0",
                     Req_chunk, Req_index, Chunk_ready, Cmp_Enable, Cmp_slot, Cmp_counter);
        end
        n_cmp++;
        if (Cmp_payload !== '0) begin
            n_bad++;
            $display("FAIL reset_payload: %h, required 0", Cmp_payload);
        end
        n_cmp++;
        if ({Busy, Done, Chain_valid, Chain_error, Err_code} !== '0) begin
            n_bad++;
            $display("FAIL reset_status: busy %0b done %0b v %0b e %0b code %0d, required all 0",
                     Busy, Done, Chain_valid, Chain_error, Err_code);
        end
        @(negedge clk);
        Reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_pass_slot1();
        config_clear();
        start_chain(2'd1, 1'b1, 1'b0, 2'd0);
        wait_done("pass", 200);
        @(negedge clk);
        n_cmp++;
        if (req_log.size() != 4) begin
            n_bad++;
            $display("FAIL pass_reqs: %0d requests, required 4", req_log.size());
        end
        for (int i = 0; i < req_log.size() && i < 4; i++) begin
            n_cmp++;
            if (req_log[i] != i + 1) begin
                n_bad++;
                $display("FAIL pass_req_index: request %0d had index %0d, required %0d", i, req_log[i], i + 1);
            end
        end
        n_cmp++;
        if (done_count != 1) begin
            n_bad++;
            $display("FAIL pass_done_count: %0d, required 1", done_count);
        end
        n_cmp++;
        if (en_rises != 4) begin
            n_bad++;
            $display("FAIL pass_enable_bursts: %0d, required 4", en_rises);
        end
        n_cmp++;
        if (Busy !== 1'b0 || Chain_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL pass_hold: busy %0b valid %0b, required 0/1", Busy, Chain_valid);
        end
    endtask

    task automatic test_mismatch_slot0();
        config_clear();
        corrupt_idx = 3;
        start_chain(2'd0, 1'b0, 1'b1, 2'd1);
        wait_done("mismatch", 200);
        @(negedge clk);
        n_cmp++;
        if (req_log.size() != 3) begin
            n_bad++;
            $display("FAIL mismatch_reqs: %0d requests, required 3", req_log.size());
        end
    endtask

    task automatic test_timeout_slot2();
        config_clear();
        silent_idx = 2;
        start_chain(2'd2, 1'b0, 1'b1, 2'd2);
        wait_done("timeout", 100);
        @(negedge clk);
        n_cmp++;
        if (done_cyc - last_req_cyc != T + 1) begin
            n_bad++;
            $display("FAIL timeout_latency: Done %0d cycles after request, required %0d", done_cyc - last_req_cyc, T + 1);
        end
        n_cmp++;
        if (req_log.size() != 2) begin
            n_bad++;
            $display("FAIL timeout_reqs: %0d requests, required 2", req_log.size());
        end
        config_clear();
        late_idx = 2;
        start_chain(2'd2, 1'b1, 1'b0, 2'd0);
        wait_done("late_chunk", 200);
        @(negedge clk);
        n_cmp++;
        if (en_rises != 5) begin
            n_bad++;
            $display("FAIL late_chunk_bursts: %0d, required 5", en_rises);
        end
    endtask

    task automatic test_bad_slot();
        config_clear();
        start_chain(2'd3, 1'b0, 1'b1, 2'd3);
        wait_done("bad_slot", 4);
        @(negedge clk);
        n_cmp++;
        if (done_cyc - start_cyc < 1 || done_cyc - start_cyc > 2) begin
            n_bad++;
            $display("FAIL bad_slot_latency: %0d cycles, required 1..2", done_cyc - start_cyc);
        end
        n_cmp++;
        if (req_log.size() != 0) begin
            n_bad++;
            $display("FAIL bad_slot_reqs: %0d requests, required 0", req_log.size());
        end
    endtask

    task automatic test_abort_reset();
        bit seen;
        config_clear();
        silent_idx = 2;
        start_chain(2'd1, 1'b1, 1'b0, 2'd0);
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = (req_log.size() >= 2);
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL abort_setup: second request not seen, required within 40 cycles");
        end
        repeat (2) @(negedge clk);
        Abort = 1'b1;
        @(negedge clk);
        Abort = 1'b0;
        n_cmp++;
        if ({Busy, Chunk_ready, Cmp_Enable, Req_chunk, Chain_valid, Chain_error, Err_code} !== '0) begin
            n_bad++;
            $display("FAIL abort_idle: busy %0b rdy %0b en %0b req %0b v %0b e %0b code %0d, required all 0",
                     Busy, Chunk_ready, Cmp_Enable, Req_chunk, Chain_valid, Chain_error, Err_code);
        end
        repeat (5) @(negedge clk);
        n_cmp++;
        if (done_count != 0) begin
            n_bad++;
            $display("FAIL abort_no_done: %0d Done pulses, required 0", done_count);
        end
        config_clear();
        start_chain(2'd1, 1'b1, 1'b0, 2'd0);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = Cmp_Enable;
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL reset_setup: Cmp_Enable not seen, required within 20 cycles");
        end
        mon_quiet = 1;
        #2;
        Reset = 1'b1;
        #1;
        n_cmp++;
        if ({Req_chunk, Req_index, Chunk_ready, Cmp_Enable, Cmp_slot, Cmp_counter, Cmp_payload,
             Busy, Done, Chain_valid, Chain_error, Err_code} !== '0) begin
            n_bad++;
            $display("FAIL async_reset: en %0b slot %0d cnt %0d payload %h busy %0b, required all 0",
                     Cmp_Enable, Cmp_slot, Cmp_counter, Cmp_payload, Busy);
        end
        @(negedge clk);
        Reset = 1'b0;
        @(negedge clk);
        mon_quiet = 0;
        config_clear();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_busy_start_both_flags();
        config_clear();
        both_idx = 2;
        start_chain(2'd1, 1'b0, 1'b1, 2'd1);
        repeat (2) @(negedge clk);
        Slot_sel = 2'd3;
        Start    = 1'b1;
        @(posedge clk);
        #1;
        Start    = 1'b0;
        Slot_sel = 2'd0;
        @(negedge clk);
        n_cmp++;
        if (Cmp_slot !== 2'd1 || Busy !== 1'b1 || Done !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_start: slot %0d busy %0b done %0b, required 1/1/0", Cmp_slot, Busy, Done);
        end
        wait_done("both_flags", 200);
        @(negedge clk);
        n_cmp++;
        if (done_count != 1 || req_log.size() != 2) begin
            n_bad++;
            $display("FAIL both_flags_seq: %0d Done, %0d requests, required 1 and 2", done_count, req_log.size());
        end
    endtask

    initial begin
        Reset    = 1'b1;
        Start    = 1'b0;
        Slot_sel = 2'd0;
        Abort    = 1'b0;
        test_reset();
        test_pass_slot1();
        test_mismatch_slot0();
        test_timeout_slot2();
        test_bad_slot();
        test_abort_reset();
        test_busy_start_both_flags();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cert_chain_sequencer.md
Name: cert_chain_sequencer

Overview:
- Drives the certificate comparator one certificate at a time for a selected slot: requests each chunk by index, accepts it over a valid/ready handshake, and presents it to the comparator.
- Evaluates the comparator verdict and aggregates the per-chunk results into a single chain pass/fail.
- Sits between the GET_CERTIFICATE response path (upstream) and certificate_compare (downstream); consumes that block's Valid_Certificate and Error_Invalid_Certificate.

Parameters:
- PAYLOAD_W, `MSG_LEN-(`SIZE_OF_HEADER_VARS*`SIZE_OF_HEADER_IN_BYTES), payload width presented to the comparator.
- SLOT0_CERTS, 6, number of certificates in slot 0.
- SLOT1_CERTS, 4, number of certificates in slot 1.
- SLOT2_CERTS, 5, number of certificates in slot 2.
- TIMEOUT_CYCLES, 1024, maximum cycles to wait for a requested chunk.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  one-cycle pulse; begins a chain check; ignored unless in IDLE.
- Slot_sel  in  2  slot to check; sampled on Start.
- Abort  in  1  returns to IDLE from any state; Done is not pulsed.
- Req_chunk  out  1  one-cycle pulse requesting a chunk.
- Req_index  out  8  1-based chunk index; valid while Req_chunk=1.
- Chunk_valid  in  1  upstream chunk present.
- Chunk_ready  out  1  sequencer accepts a chunk.
- Chunk_data  in  PAYLOAD_W  chunk payload.
- Cmp_Enable  out  1  comparator enable.
- Cmp_slot  out  2  comparator slot.
- Cmp_counter  out  8  comparator certificate index.
- Cmp_payload  out  PAYLOAD_W  registered chunk.
- Cmp_valid  in  1  from comparator Valid_Certificate.
- Cmp_error  in  1  from comparator Error_Invalid_Certificate.
- Busy  out  1  high in any state other than IDLE.
- Done  out  1  one-cycle pulse on entry to DONE.
- Chain_valid  out  1  sticky pass result.
- Chain_error  out  1  sticky fail result.
- Err_code  out  2  failure reason: 0 none, 1 mismatch, 2 timeout, 3 bad slot or no verdict.

Behaviour:
- Reset (asynchronous):
  - State goes to IDLE.
  - Every output is 0, including Cmp_payload, Req_index and Err_code.
  - The chunk counter and the timeout counter are cleared.
- IDLE:
  - On Start, clear Chain_valid, Chain_error and Err_code and latch Slot_sel into Cmp_slot.
  - Slot 3 goes to DONE with Err_code=3 and Chain_error=1.
  - Any other slot sets counter=1 and goes to REQ.
  - last is SLOTn_CERTS for the latched slot.
- REQ: Req_chunk=1 and Req_index=counter for exactly one cycle; Cmp_Enable=0; go to WAIT.
- WAIT:
  - Chunk_ready=1 and the timeout counter increments.
  - Chunk_valid & Chunk_ready: register Chunk_data into Cmp_payload, set Cmp_counter=counter, clear the timeout counter, go to CHECK.
  - Timeout counter reaching TIMEOUT_CYCLES-1 with no chunk: go to DONE with Err_code=2.
  - Chunk_valid in that same final cycle wins over the timeout.
- CHECK: Cmp_Enable=1; Cmp_slot, Cmp_counter and Cmp_payload are held stable; go to EVAL.
- EVAL (comparator output is registered, so the verdict is visible here):
  - Cmp_Enable stays 1 this cycle; Cmp_error is checked first.
  - Cmp_error=1: go to DONE with Err_code=1. This also applies when Cmp_error and Cmp_valid are both 1.
  - Cmp_valid=1 and counter==last: go to DONE with a pass.
  - Cmp_valid=1 and counter<last: counter+1, go to REQ.
  - Neither asserted: go to DONE with Err_code=3.
- Comparator spacing:
  - Cmp_Enable drops for at least one cycle (REQ) between chunks, so the comparator's sticky flags clear before the next evaluation.
  - Cmp_Enable is never high outside CHECK and EVAL.
- DONE:
  - Done=1 for one cycle.
  - Chain_valid=1 on pass; Chain_error=1 on failure.
  - Both results and Err_code hold until the next Start.
  - Go to IDLE.
- Abort:
  - Next state is IDLE; Cmp_Enable, Chunk_ready and Req_chunk go low next cycle.
  - Chain_valid and Chain_error stay 0; Err_code is unchanged.
  - Abort has priority over every transition, including DONE entry.
- Start outside IDLE is ignored.
- Counter width is 8 bits; the SLOTn_CERTS parameters must be 1..255, so the counter never wraps.

Decomposition:
- Shared package/header holds:
  - state encoding;
  - Err_code constants;
  - slot constants SLOT0 to SLOT2;
  - per-slot certificate counts, shared with the comparator's table.
- One natural sub-module is cert_chunk_timeout: a loadable down-counter with clear and an expiry flag, used in WAIT.

Test Plan:
- Slot 1, four correct chunks, Chunk_valid 2 cycles after each Req_chunk:
  - Req_index sequence 1,2,3,4.
  - Done pulses once; Chain_valid=1, Err_code=0.
  - Cmp_Enable is low between every chunk pair.
- Slot 0, chunk 3 corrupted (Cmp_error=1 in EVAL):
  - Done follows with Chain_error=1, Err_code=1.
  - Req_index never reaches 4.
- Slot 2, upstream silent after the Req_index=2 request:
  - Done fires TIMEOUT_CYCLES cycles later with Err_code=2.
  - Chunk_valid in the final cycle instead proceeds to CHECK.
- Start with Slot_sel=3:
  - Done within 2 cycles with Err_code=3.
  - Req_chunk is never asserted.
- Abort during WAIT of chunk 2, then Reset asserted mid-CHECK:
  - After Abort: IDLE next cycle, Busy=0, no Done.
  - After Reset: all outputs 0 immediately, asynchronously.
- Start pulsed while Busy, plus Cmp_valid and Cmp_error both high in EVAL:
  - The Start is ignored.
  - The verdict is a failure with Err_code=1.
